// File: rtl/sixbit_inverse_factorial_pkg.sv
// Shared types for the inverse-factorial search: FSM state codes and the
// result-case codes that select how a finished search is reported.
package sixbit_inverse_factorial_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Outcome of one RUN-cycle evaluation, in decreasing priority.
    typedef enum logic [2:0] {
        ResNone  = 3'd0,
        ResExact = 3'd1,
        ResBelow = 3'd2,
        ResOvf   = 3'd3,
        ResNext  = 3'd4
    } result_e;

endpackage

// File: rtl/sixbit_inverse_factorial_step_mul.sv
// Combinational WIDTH x NW multiplier for one search step: truncated product
// plus a flag for any bits lost above WIDTH.
module sixbit_inverse_factorial_step_mul #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned NW    = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [NW-1:0]    b,
    output logic [WIDTH-1:0] p,
    output logic             ovf
);

    logic [WIDTH+NW-1:0] full;

    always_comb begin
        full = {{NW{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        p    = full[WIDTH-1:0];
        ovf  = |full[WIDTH+NW-1:WIDTH];
    end

endmodule

// File: rtl/sixbit_inverse_factorial.sv
// Iterative inverse factorial: finds n with n! == ain, else floor n (or ceiling n
// when INVFACT_CEIL_EN is defined). One multiply step per clock.
module sixbit_inverse_factorial
    import sixbit_inverse_factorial_pkg::*;
#(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned NW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] ain,
    output logic             busy,
    output logic             done,
    output logic [NW-1:0]    n,
    output logic             exact,
    output logic             overflow
);

    // Keeps k+1 representable in NW bits even if the product never overflows.
    localparam logic [NW-1:0] KCap = NW'((2 ** NW) - 2);

    state_e           state;
    result_e          res;
    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] prod;
    logic [NW-1:0]    k;
    logic [NW-1:0]    k_inc;
    logic [WIDTH-1:0] nxt;
    logic             mov;
    logic [NW-1:0]    n_inexact;

    assign k_inc = k + NW'(1);

    sixbit_inverse_factorial_step_mul #(
        .WIDTH (WIDTH),
        .NW    (NW)
    ) u_step_mul (
        .a   (prod),
        .b   (k_inc),
        .p   (nxt),
        .ovf (mov)
    );

`ifdef INVFACT_CEIL_EN
    assign n_inexact = k_inc;
`else
    assign n_inexact = k;
`endif

    always_comb begin
        res = ResNone;
        if (prod == tgt) begin
            res = ResExact;
        end else if (prod > tgt) begin
            res = ResBelow;
        end else if (mov || (k == KCap)) begin
            res = ResOvf;
        end else if (nxt > tgt) begin
            res = ResNext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            busy     <= 1'b0;
            done     <= 1'b0;
            n        <= '0;
            exact    <= 1'b0;
            overflow <= 1'b0;
            tgt      <= '0;
            prod     <= '0;
            k        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle, StDone: begin
                    if (start) begin
                        tgt      <= ain;
                        prod     <= WIDTH'(1);
                        k        <= NW'(1);
                        n        <= '0;
                        exact    <= 1'b0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        state    <= StRun;
                    end else begin
                        state <= StIdle;
                    end
                end
                StRun: begin
                    if (res == ResNone) begin
                        prod <= nxt;
                        k    <= k_inc;
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StDone;
                        case (res)
                            ResExact: begin
                                n        <= k;
                                exact    <= 1'b1;
                                overflow <= 1'b0;
                            end
                            // Only reachable for ain=0, where k is still 1.
                            ResBelow: begin
                                n        <= k - NW'(1);
                                exact    <= 1'b0;
                                overflow <= 1'b0;
                            end
                            ResOvf: begin
                                n        <= n_inexact;
                                exact    <= 1'b0;
                                overflow <= 1'b1;
                            end
                            default: begin
                                n        <= n_inexact;
                                exact    <= 1'b0;
                                overflow <= 1'b0;
                            end
                        endcase
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sixbit_inverse_factorial.sv
// Scoreboard bench for sixbit_inverse_factorial: expectations come from a
// factorial lookup model and are compared when done pulses.
module tb_sixbit_inverse_factorial;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [5:0] ain;
    logic       busy;
    logic       done;
    logic [3:0] n;
    logic       exact;
    logic       overflow;

    typedef struct {
        int a;
        int n;
        int exact;
        int ovf;
        int lat;
        int t;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;

    sixbit_inverse_factorial #(
        .WIDTH (6),
        .NW    (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ain      (ain),
        .busy     (busy),
        .done     (done),
        .n        (n),
        .exact    (exact),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Largest m>=1 with m! <= a (0 for a=0); search takes max(m,1) RUN cycles.
    function automatic exp_t model(input int a);
        int   fact[5] = '{1, 1, 2, 6, 24};
        exp_t e;
        int   m = 0;
        for (int i = 1; i < 5; i++) if (fact[i] <= a) m = i;
        e.a     = a;
        e.exact = (a != 0 && fact[m] == a) ? 1 : 0;
        e.ovf   = (a != 0 && e.exact == 0 && m == 4) ? 1 : 0;
        e.n     = m;
`ifdef INVFACT_CEIL_EN
        if (a != 0 && e.exact == 0) e.n = m + 1;
`endif
        e.lat   = 1 + ((m == 0) ? 1 : m);
        e.t     = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            if (q.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                mon_e = q.pop_front();
                check($sformatf("n_ain%0d", mon_e.a), n, mon_e.n);
                check($sformatf("exact_ain%0d", mon_e.a), exact, mon_e.exact);
                check($sformatf("ovf_ain%0d", mon_e.a), overflow, mon_e.ovf);
                check($sformatf("lat_ain%0d", mon_e.a), cyc - mon_e.t, mon_e.lat);
            end
            done_cnt++;
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy !== 1'b0; i++) @(negedge clk);
        if (busy !== 1'b0) check("idle_timeout", busy, 0);
    endtask

    task automatic wait_done(input int prev, input string tag);
        for (int i = 0; i < 40 && done_cnt == prev; i++) @(negedge clk);
        if (done_cnt == prev) check({tag, "_timeout"}, 0, 1);
    endtask

    // Called at a negedge with busy low; start is accepted at the next posedge.
    task automatic launch(input int a);
        exp_t e;
        e   = model(a);
        e.t = cyc;
        q.push_back(e);
        start = 1'b1;
        ain   = 6'(a);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run(input int a);
        exp_t e;
        bit   seen = 0;
        e = model(a);
        wait_idle();
        launch(a);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
            else check($sformatf("busy_ain%0d", a), busy, 1);
        end
        if (!seen) check($sformatf("done_timeout_ain%0d", a), 0, 1);
        @(negedge clk);
        check($sformatf("hold_n_ain%0d", a), n, e.n);
        check($sformatf("pulse_ain%0d", a), {busy, done}, 0);
    endtask

    initial begin
        int   prev;
        exp_t e;
        rst   = 1'b1;
        start = 1'b0;
        ain   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {busy, done, n, exact, overflow}, 0);
        rst = 1'b0;
        @(negedge clk);

        run(24);
        run(7);
        run(63);
        run(1);
        run(0);
        run(2);

        // Start during RUN must be ignored.
        wait_idle();
        prev = done_cnt;
        launch(24);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        ain   = 6'd2;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(prev, "ignored_start");
        @(negedge clk);

        // Reset mid-search aborts without a done pulse.
        wait_idle();
        prev  = done_cnt;
        start = 1'b1;
        ain   = 6'd24;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_outputs", {busy, done, n, exact, overflow}, 0);
        repeat (10) @(negedge clk);
        check("abort_no_done", done_cnt, prev);

        // Start held through the DONE cycle launches the next run there.
        e   = model(24);
        e.t = cyc;
        q.push_back(e);
        start = 1'b1;
        ain   = 6'd24;
        @(posedge clk);
        #1 ain = 6'd6;
        for (int i = 0; i < 40 && done !== 1'b1; i++) @(negedge clk);
        check("b2b_first_done", done, 1);
        e   = model(6);
        e.t = cyc;
        q.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
        prev = done_cnt;
        wait_done(prev, "b2b_second");
        @(negedge clk);

        for (int a = 0; a < 64; a++) run(a);

        check("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
